// File: rtl/packer_sched_pkg.sv
// Shared types for the packet-granular round-robin packer scheduler.
package packer_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    XFER,
    DROP,
    GAP
  } sched_state_t;

  typedef struct packed {
    logic [7:0] k;
    logic [7:0] packet_length;
  } packer_cfg_t;

  // The packer needs a non-empty packet and a non-zero k that fits inside it.
  function automatic logic cfg_legal(input packer_cfg_t c);
    return (c.packet_length != 8'd0) && (c.k != 8'd0) && (c.k <= c.packet_length);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int NUM_SRC = 4,
  localparam int GNT_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [GNT_W-1:0]   ptr,
  output logic [GNT_W-1:0]   gnt,
  output logic               any_req
);

  logic [NUM_SRC-1:0] rot;
  logic [GNT_W-1:0]   off;
  logic [GNT_W:0]     sum;

  // rot[gi] is the request gi positions past the pointer.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_rot
      logic [GNT_W:0]   idx;
      logic [GNT_W-1:0] idx_w;
      assign idx     = {1'b0, ptr} + (GNT_W+1)'(gi);
      assign idx_w   = GNT_W'((idx >= (GNT_W+1)'(NUM_SRC)) ? idx - (GNT_W+1)'(NUM_SRC) : idx);
      assign rot[gi] = req[idx_w];
    end
  endgenerate

  always_comb begin
    off     = '0;
    any_req = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off     = GNT_W'(i);
        any_req = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    gnt = GNT_W'((sum >= (GNT_W+1)'(NUM_SRC)) ? sum - (GNT_W+1)'(NUM_SRC) : sum);
  end

endmodule

// File: rtl/packer_rr_scheduler.sv
// Shares one data_packer among NUM_SRC AXI-stream sources, one packet per grant.
// Define PACKER_SCHED_STATS_EN to add the pkt_cnt / drop_cnt statistics ports.
module packer_rr_scheduler
  import packer_sched_pkg::*;
#(
  parameter  int NUM_SRC    = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int GNT_W      = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]            s_tvalid,
  output logic [NUM_SRC-1:0]            s_tready,
  input  logic [NUM_SRC-1:0]            s_tlast,
  input  logic [NUM_SRC*16-1:0]         cfg_src,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic [15:0]                   confi,
  output logic [GNT_W-1:0]              grant_id,
  output logic                          busy,
  output logic                          cfg_err,
  output logic                          len_err
`ifdef PACKER_SCHED_STATS_EN
  ,
  output logic [NUM_SRC*16-1:0]         pkt_cnt,
  output logic [15:0]                   drop_cnt
`endif
);

  sched_state_t state_reg, state_next;
  logic [GNT_W-1:0] grant_reg, rr_ptr_reg, arb_gnt;
  logic             any_req;
  packer_cfg_t      cfg_q, confi_reg;
  logic [7:0]       beat_cnt_reg;

  logic [DATA_WIDTH-1:0] src_data [NUM_SRC];
  packer_cfg_t           src_cfg  [NUM_SRC];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
      assign src_data[gi] = s_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign src_cfg[gi]  = cfg_src[gi*16 +: 16];
    end
  endgenerate

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .req     (s_tvalid),
    .ptr     (rr_ptr_reg),
    .gnt     (arb_gnt),
    .any_req (any_req)
  );

  logic sel_valid, sel_last, cfg_ok, at_len, xfer_hs;
  assign sel_valid = s_tvalid[grant_reg];
  assign sel_last  = s_tlast[grant_reg];
  assign cfg_ok    = cfg_legal(cfg_q);
  assign at_len    = (beat_cnt_reg == (cfg_q.packet_length - 8'd1));
  assign xfer_hs   = (state_reg == XFER) && sel_valid && m_tready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // cfg_q is captured with the grant so legality is judged on a stable value in GRANT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_reg    <= '0;
      rr_ptr_reg   <= '0;
      cfg_q        <= '0;
      confi_reg    <= '0;
      beat_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            grant_reg <= arb_gnt;
            cfg_q     <= src_cfg[arb_gnt];
          end
        end
        GRANT: begin
          beat_cnt_reg <= '0;
          if (cfg_ok) begin
            confi_reg <= cfg_q;
          end
        end
        XFER: begin
          if (xfer_hs) begin
            beat_cnt_reg <= beat_cnt_reg + 8'd1;
          end
        end
        GAP: begin
          rr_ptr_reg <= (grant_reg == GNT_W'(NUM_SRC - 1)) ? '0 : grant_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (any_req) state_next = GRANT;
      GRANT: state_next = cfg_ok ? XFER : DROP;
      XFER: begin
        if (xfer_hs) begin
          if (sel_last)    state_next = GAP;
          else if (at_len) state_next = DROP;
        end
      end
      DROP:  if (sel_valid && sel_last) state_next = GAP;
      GAP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_tready = '0;
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    cfg_err  = 1'b0;
    len_err  = 1'b0;
    busy     = (state_reg != IDLE);
    case (state_reg)
      GRANT: cfg_err = !cfg_ok;
      XFER: begin
        m_tdata             = src_data[grant_reg];
        m_tvalid            = sel_valid;
        m_tlast             = sel_last | at_len;
        s_tready[grant_reg] = m_tready;
        len_err             = xfer_hs && !sel_last && at_len;
      end
      DROP: s_tready[grant_reg] = 1'b1;
      default: ;
    endcase
  end

  assign confi    = confi_reg;
  assign grant_id = grant_reg;

`ifdef PACKER_SCHED_STATS_EN
  logic [15:0] drop_cnt_reg;

  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_stats
      logic [15:0] cnt_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (xfer_hs && sel_last && (grant_reg == GNT_W'(gi)) && (cnt_reg != 16'hFFFF)) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end
      assign pkt_cnt[gi*16 +: 16] = cnt_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_reg <= '0;
    end else if ((cfg_err || len_err) && (drop_cnt_reg != 16'hFFFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_packer_rr_scheduler.sv
// Scoreboard bench for packer_rr_scheduler: directed packets, expected beats queued, monitor compares.
module tb_packer_rr_scheduler;

  localparam int NS = 4;
  localparam int DW = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [NS*DW-1:0] s_tdata;
  logic [NS-1:0]    s_tvalid;
  logic [NS-1:0]    s_tready;
  logic [NS-1:0]    s_tlast;
  logic [NS*16-1:0] cfg_src;
  logic [DW-1:0]    m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;
  logic [15:0]      confi;
  logic [1:0]       grant_id;
  logic             busy;
  logic             cfg_err;
  logic             len_err;
`ifdef PACKER_SCHED_STATS_EN
  logic [NS*16-1:0] pkt_cnt;
  logic [15:0]      drop_cnt;
`endif

  packer_rr_scheduler #(.NUM_SRC(NS), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tlast  (s_tlast),
    .cfg_src  (cfg_src),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .confi    (confi),
    .grant_id (grant_id),
    .busy     (busy),
    .cfg_err  (cfg_err),
    .len_err  (len_err)
`ifdef PACKER_SCHED_STATS_EN
    ,
    .pkt_cnt  (pkt_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  data;
    logic        last;
    logic [1:0]  gid;
    logic [15:0] confi;
    logic [7:0]  gap;
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int errors = 0;

  logic [8:0] src_mem [NS][256];
  int wr_ptr [NS];
  int rd_ptr [NS];

  logic       ready_pat_en = 1'b0;
  logic [3:0] ready_pat    = 4'b1001;

  int cyc = 0;
  int last_hs_cyc = 0;
  int beats_seen = 0;
  int cfg_err_seen = 0;
  int len_err_seen = 0;
  int drop_probe = -1;
  logic [15:0] confi_drop = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_pkt(input int src, input int n, input logic [7:0] base);
    for (int j = 0; j < n; j++) begin
      src_mem[src][wr_ptr[src]] = {(j == n - 1), base + 8'(j)};
      wr_ptr[src]++;
    end
  endtask

  task automatic exp_pkt(input int gid, input int n, input logic [7:0] base, input logic [15:0] cf,
                         input logic [7:0] gap_first, input logic [7:0] gap_inner, input logic with_last);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      e.data  = base + 8'(j);
      e.last  = with_last && (j == n - 1);
      e.gid   = 2'(gid);
      e.confi = cf;
      e.gap   = (j == 0) ? gap_first : gap_inner;
      expq.push_back(e);
    end
  endtask

  task automatic set_cfg(input int src, input logic [15:0] v);
    cfg_src[src*16 +: 16] = v;
  endtask

  function automatic logic pending();
    for (int i = 0; i < NS; i++) if (rd_ptr[i] < wr_ptr[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while ((expq.size() != 0 || busy || pending()) && n < 2000);
    check({name, "_timeout"}, 64'(n >= 2000), 64'd0);
  endtask

  // Source model: pop beats the DUT accepted, then present the next one.
  initial begin
    logic [NS-1:0] took;
    int pc;
    pc = 0;
    forever begin
      @(negedge clk);
      took = s_tvalid & s_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (took[i] && rd_ptr[i] < wr_ptr[i]) rd_ptr[i]++;
        if (rd_ptr[i] < wr_ptr[i]) begin
          s_tvalid[i]       = 1'b1;
          s_tdata[i*DW +: DW] = src_mem[i][rd_ptr[i]][7:0];
          s_tlast[i]        = src_mem[i][rd_ptr[i]][8];
        end else begin
          s_tvalid[i]       = 1'b0;
          s_tdata[i*DW +: DW] = '0;
          s_tlast[i]        = 1'b0;
        end
      end
      if (ready_pat_en) begin
        m_tready = ready_pat[pc % 4];
        pc++;
      end else begin
        m_tready = 1'b1;
      end
    end
  end

  // Monitor: compares every presented handshake against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (cfg_err) begin
          cfg_err_seen++;
          drop_probe = cyc + 2;
        end
        if (len_err) len_err_seen++;
        if (cyc == drop_probe) confi_drop = confi;
        if (m_tvalid)
          check("s_tready_mirror", 64'(s_tready), 64'(m_tready ? (4'b0001 << grant_id) : 4'b0000));
        if (m_tvalid && m_tready) begin
          if (expq.size() == 0) begin
            check("unexpected_beat", {m_tdata, m_tlast, grant_id, confi}, 64'h0);
          end else begin
            e = expq.pop_front();
            $display("beat src=%0d data=%02h last=%0b confi=%04h", grant_id, m_tdata, m_tlast, confi);
            check("beat", {m_tdata, m_tlast, grant_id, confi}, {e.data, e.last, e.gid, e.confi});
            if (e.gap != 0) check("beat_spacing", 64'(cyc - last_hs_cyc), 64'(e.gap));
          end
          last_hs_cyc = cyc;
          beats_seen++;
        end
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_cnt;
    int n;
    reset    = 1'b1;
    s_tdata  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b1;
    cfg_src  = '0;
    for (int i = 0; i < NS; i++) begin
      wr_ptr[i] = 0;
      rd_ptr[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {m_tdata, m_tvalid, m_tlast, s_tready, confi, grant_id, busy, cfg_err, len_err}, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // Four sources contending: grants 0,1,2,3,0 with fixed inter-packet spacing.
    set_cfg(0, 16'h0104);
    set_cfg(1, 16'h0204);
    set_cfg(2, 16'h0304);
    set_cfg(3, 16'h0404);
    push_pkt(0, 3, 8'h10);
    push_pkt(0, 3, 8'h50);
    push_pkt(1, 3, 8'h20);
    push_pkt(2, 3, 8'h30);
    push_pkt(3, 3, 8'h40);
    exp_pkt(0, 3, 8'h10, 16'h0104, 8'd0, 8'd1, 1'b1);
    exp_pkt(1, 3, 8'h20, 16'h0204, 8'd4, 8'd1, 1'b1);
    exp_pkt(2, 3, 8'h30, 16'h0304, 8'd4, 8'd1, 1'b1);
    exp_pkt(3, 3, 8'h40, 16'h0404, 8'd4, 8'd1, 1'b1);
    exp_pkt(0, 3, 8'h50, 16'h0104, 8'd4, 8'd1, 1'b1);
    wait_done("rr_four");

    // Single source, 8-beat packet ending exactly at packet_length.
    set_cfg(0, 16'h0208);
    base_cnt = len_err_seen;
    push_pkt(0, 8, 8'h01);
    exp_pkt(0, 8, 8'h01, 16'h0208, 8'd0, 8'd1, 1'b1);
    wait_done("single_src");
    check("single_confi", 64'(confi), 64'h0208);
    check("single_no_len_err", 64'(len_err_seen - base_cnt), 64'd0);

    // Illegal k on source 2 is dropped; source 3 then a single-beat source 0 follow.
    set_cfg(2, 16'h0908);
    set_cfg(3, 16'h0102);
    base_cnt = cfg_err_seen;
    push_pkt(2, 8, 8'hC0);
    push_pkt(3, 2, 8'h60);
    push_pkt(0, 1, 8'h77);
    exp_pkt(3, 2, 8'h60, 16'h0102, 8'd0, 8'd1, 1'b1);
    exp_pkt(0, 1, 8'h77, 16'h0208, 8'd0, 8'd0, 1'b1);
    wait_done("cfg_drop");
    check("cfg_err_count", 64'(cfg_err_seen - base_cnt), 64'd1);
    check("confi_during_drop", 64'(confi_drop), 64'h0208);
    check("src2_drained", 64'(wr_ptr[2] - rd_ptr[2]), 64'd0);

    // Source 1 overruns packet_length=4 by two beats.
    set_cfg(1, 16'h0104);
    base_cnt = len_err_seen;
    push_pkt(1, 6, 8'h80);
    exp_pkt(1, 4, 8'h80, 16'h0104, 8'd0, 8'd0, 1'b1);
    wait_done("truncate");
    check("len_err_count", 64'(len_err_seen - base_cnt), 64'd1);
    check("src1_drained", 64'(wr_ptr[1] - rd_ptr[1]), 64'd0);

    // Back-pressure pattern 1,0,0,1 on the packer side.
    set_cfg(2, 16'h0203);
    ready_pat_en = 1'b1;
    push_pkt(2, 3, 8'hA0);
    exp_pkt(2, 3, 8'hA0, 16'h0203, 8'd0, 8'd0, 1'b1);
    wait_done("backpressure");
    ready_pat_en = 1'b0;
    check("bp_confi", 64'(confi), 64'h0203);

    // Reset while the 3rd beat of a source 1 packet is on the bus.
    set_cfg(1, 16'h0105);
    push_pkt(1, 5, 8'hE1);
    exp_pkt(1, 3, 8'hE1, 16'h0105, 8'd0, 8'd1, 1'b0);
    base_cnt = beats_seen + 3;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (beats_seen < base_cnt && n < 200);
    check("reset_wait_timeout", 64'(n >= 200), 64'd0);
    reset = 1'b1;
    #1;
    check("midpkt_reset_outputs",
          {m_tdata, m_tvalid, m_tlast, s_tready, confi, grant_id, busy, cfg_err, len_err}, 64'h0);
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < NS; i++) rd_ptr[i] = wr_ptr[i];
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    check("scoreboard_empty_at_reset", 64'(expq.size()), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // With the pointer cleared, source 0 must win over source 3.
    set_cfg(3, 16'h0104);
    push_pkt(0, 2, 8'h91);
    push_pkt(3, 1, 8'hB3);
    exp_pkt(0, 2, 8'h91, 16'h0208, 8'd0, 8'd1, 1'b1);
    exp_pkt(3, 1, 8'hB3, 16'h0104, 8'd0, 8'd0, 1'b1);
    wait_done("post_reset");
`ifdef PACKER_SCHED_STATS_EN
    check("stats_drop_cnt", 64'(drop_cnt), 64'd0);
    check("stats_pkt_cnt0", 64'(pkt_cnt[0 +: 16]), 64'd1);
    check("stats_pkt_cnt3", 64'(pkt_cnt[48 +: 16]), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
